// File: rtl/layer_compositor_if.sv
// Pixel-pipeline bus between the sync generator/game logic and the layer compositor.
// The master side drives the counters and object positions. The slave side returns colour and collision status.
interface layer_compositor_if #(
   parameter int unsigned NUM_CARS   = 6,
   parameter int unsigned COLOR_BITS = 3,
   parameter int unsigned ADDR_W     = 10
);
   logic [9:0]                h_count;
   logic [9:0]                v_count;
   logic [9:0]                player_x;
   logic [9:0]                player_y;
   logic [10*NUM_CARS-1:0]    car_x;
   logic [10*NUM_CARS-1:0]    car_y;
   logic [9:0]                sprite_x;
   logic [9:0]                sprite_y;
   logic                      sprite_en;
   logic [ADDR_W-1:0]         sprite_addr;
   logic [3*COLOR_BITS-1:0]   sprite_data;
   logic                      collision_clr;
   logic [COLOR_BITS-1:0]     VGA_R;
   logic [COLOR_BITS-1:0]     VGA_G;
   logic [COLOR_BITS-1:0]     VGA_B;
   logic                      collision_pulse;
   logic                      collision_sticky;

   modport master (
      output h_count, v_count, player_x, player_y, car_x, car_y,
             sprite_x, sprite_y, sprite_en, sprite_data, collision_clr,
      input  sprite_addr, VGA_R, VGA_G, VGA_B, collision_pulse, collision_sticky
   );

   modport slave (
      input  h_count, v_count, player_x, player_y, car_x, car_y,
             sprite_x, sprite_y, sprite_en, sprite_data, collision_clr,
      output sprite_addr, VGA_R, VGA_G, VGA_B, collision_pulse, collision_sticky
   );
endinterface

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: stage 1 registers layer hits and the sprite ROM address.
// Stage 2 registers the priority-muxed colour. It also reports player/car collisions once per frame.
module layer_compositor #(
   parameter int unsigned NUM_CARS    = 6,
   parameter int unsigned COLOR_BITS  = 3,
   parameter int unsigned H_DISPLAY   = 640,
   parameter int unsigned V_DISPLAY   = 480,
   parameter int unsigned PLAYER_W    = 32,
   parameter int unsigned PLAYER_H    = 32,
   parameter int unsigned CAR_W       = 64,
   parameter int unsigned CAR_H       = 32,
   parameter int unsigned SAFE_Y0     = 0,
   parameter int unsigned SAFE_Y1     = 224,
   parameter int unsigned SAFE_Y2     = 448,
   parameter int unsigned SAFE_H      = 32,
   parameter int unsigned SPRITE_SIZE = 32,
   parameter int unsigned ADDR_W      = 10
) (
   input  logic              CLK,
   input  logic              RST_N,
   layer_compositor_if.slave bus
);
   localparam int unsigned POS_W = 10;
   localparam int unsigned SUM_W = POS_W + 1;

   // Half-open span test. The upper bound is one bit wider, so it cannot wrap past 1023.
   function automatic logic in_span(input logic [POS_W-1:0] p,
                                    input logic [POS_W-1:0] o,
                                    input int unsigned      w);
      return (p >= o) && ({1'b0, p} < ({1'b0, o} + SUM_W'(w)));
   endfunction

   logic [POS_W-1:0]    h_c;
   logic [POS_W-1:0]    v_c;
   logic [POS_W-1:0]    dx_c;
   logic [POS_W-1:0]    dy_c;
   logic                visible_c;
   logic                player_hit_c;
   logic [NUM_CARS-1:0] car_hit_c;
   logic                sprite_hit_c;
   logic                safe_hit_c;
   logic                frame_end_c;
   logic                coll_hit_c;
   logic [ADDR_W-1:0]   addr_c;

   logic                visible_q;
   logic                player_hit_q;
   logic [NUM_CARS-1:0] car_hit_q;
   logic                sprite_hit_q;
   logic                sprite_en_q;
   logic                safe_hit_q;
   logic                coll_acc_q;

   logic [COLOR_BITS-1:0] r_c;
   logic [COLOR_BITS-1:0] g_c;
   logic [COLOR_BITS-1:0] b_c;
   logic                  sticky_c;

   assign h_c = bus.h_count;
   assign v_c = bus.v_count;

   // Stage-1 combinational hit detection
   always_comb begin
      car_hit_c    = '0;
      visible_c    = ({1'b0, h_c} < SUM_W'(H_DISPLAY)) && ({1'b0, v_c} < SUM_W'(V_DISPLAY));
      player_hit_c = in_span(h_c, bus.player_x, PLAYER_W) && in_span(v_c, bus.player_y, PLAYER_H);
      for (int i = 0; i < int'(NUM_CARS); i++) begin
         car_hit_c[i] = in_span(h_c, bus.car_x[10*i +: 10], CAR_W)
                     && in_span(v_c, bus.car_y[10*i +: 10], CAR_H);
      end
      sprite_hit_c = in_span(h_c, bus.sprite_x, SPRITE_SIZE) && in_span(v_c, bus.sprite_y, SPRITE_SIZE);
      safe_hit_c   = in_span(v_c, POS_W'(SAFE_Y0), SAFE_H)
                  || in_span(v_c, POS_W'(SAFE_Y1), SAFE_H)
                  || in_span(v_c, POS_W'(SAFE_Y2), SAFE_H);
      dx_c         = h_c - bus.sprite_x;
      dy_c         = v_c - bus.sprite_y;
      addr_c       = ADDR_W'(32'(dy_c) * 32'(SPRITE_SIZE) + 32'(dx_c));
      frame_end_c  = (h_c == '0) && ({1'b0, v_c} == SUM_W'(V_DISPLAY));
      coll_hit_c   = visible_c && player_hit_c && (|car_hit_c);
   end

   // Stage-1 registers and the frame collision accumulator
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         visible_q            <= 1'b0;
         player_hit_q         <= 1'b0;
         car_hit_q            <= '0;
         sprite_hit_q         <= 1'b0;
         sprite_en_q          <= 1'b0;
         safe_hit_q           <= 1'b0;
         coll_acc_q           <= 1'b0;
         bus.sprite_addr      <= '0;
         bus.collision_pulse  <= 1'b0;
         bus.collision_sticky <= 1'b0;
      end else begin
         visible_q            <= visible_c;
         player_hit_q         <= player_hit_c;
         car_hit_q            <= car_hit_c;
         sprite_hit_q         <= sprite_hit_c;
         sprite_en_q          <= bus.sprite_en;
         safe_hit_q           <= safe_hit_c;
         if (sprite_hit_c) begin
            bus.sprite_addr <= addr_c;
         end
         // Frame end is never visible, so clearing and setting the accumulator cannot collide
         if (frame_end_c) begin
            coll_acc_q <= 1'b0;
         end else if (coll_hit_c) begin
            coll_acc_q <= 1'b1;
         end
         bus.collision_pulse  <= frame_end_c && coll_acc_q;
         bus.collision_sticky <= sticky_c;
      end
   end

   // A frame-end set takes priority over a simultaneous clear
   always_comb begin
      sticky_c = bus.collision_sticky;
      if (frame_end_c && coll_acc_q) begin
         sticky_c = 1'b1;
      end else if (bus.collision_clr) begin
         sticky_c = 1'b0;
      end
   end

   // Stage-2 layer priority: player, cars, opaque sprite, safe band, background
   always_comb begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
      if (!visible_q) begin
         r_c = '0;
      end else if (player_hit_q) begin
         g_c = '1;
      end else if (|car_hit_q) begin
         r_c = '1;
      end else if (sprite_en_q && sprite_hit_q && (bus.sprite_data != '0)) begin
         r_c = bus.sprite_data[0 +: COLOR_BITS];
         g_c = bus.sprite_data[COLOR_BITS +: COLOR_BITS];
         b_c = bus.sprite_data[2*COLOR_BITS +: COLOR_BITS];
      end else if (safe_hit_q) begin
         r_c = '1;
         g_c = '1;
         b_c = '1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.VGA_R <= '0;
         bus.VGA_G <= '0;
         bus.VGA_B <= '0;
      end else begin
         bus.VGA_R <= r_c;
         bus.VGA_G <= g_c;
         bus.VGA_B <= b_c;
      end
   end
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: colour priority, pipeline latency, sprite addressing, collision reporting.
module tb_layer_compositor;
   localparam int unsigned NC = 6;
   localparam int unsigned CB = 3;
   localparam int unsigned AW = 10;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   layer_compositor_if #(.NUM_CARS(NC), .COLOR_BITS(CB), .ADDR_W(AW)) bus();

   layer_compositor #(.NUM_CARS(NC), .COLOR_BITS(CB), .ADDR_W(AW)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rgb(input string tag, input int r, input int g, input int b);
      chk({tag, "_R"}, 32'(bus.VGA_R), 32'(r));
      chk({tag, "_G"}, 32'(bus.VGA_G), 32'(g));
      chk({tag, "_B"}, 32'(bus.VGA_B), 32'(b));
   endtask

   task automatic set_car(input int i, input logic [9:0] x, input logic [9:0] y);
      bus.car_x[10*i +: 10] = x;
      bus.car_y[10*i +: 10] = y;
   endtask

   task automatic park_cars();
      for (int i = 0; i < int'(NC); i++) set_car(i, 10'd0, 10'd600);
   endtask

   // Drive counters at a falling edge and advance to the next falling edge (stage 1 loaded)
   task automatic pix(input logic [9:0] h, input logic [9:0] v);
      bus.h_count = h;
      bus.v_count = v;
      @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.h_count = '0; bus.v_count = '0;
      bus.player_x = '0; bus.player_y = '0;
      bus.car_x = '0; bus.car_y = '0;
      bus.sprite_x = '0; bus.sprite_y = '0;
      bus.sprite_en = 1'b0; bus.sprite_data = '0; bus.collision_clr = 1'b0;

      // Reset held with random inputs
      repeat (4) begin
         @(negedge clk);
         bus.h_count       = 10'($urandom);
         bus.v_count       = 10'($urandom);
         bus.player_x      = 10'($urandom);
         bus.player_y      = 10'($urandom);
         bus.car_x         = 60'({$urandom, $urandom});
         bus.car_y         = 60'({$urandom, $urandom});
         bus.sprite_x      = 10'($urandom);
         bus.sprite_y      = 10'($urandom);
         bus.sprite_en     = 1'($urandom);
         bus.sprite_data   = 9'($urandom);
         bus.collision_clr = 1'($urandom);
      end
      @(negedge clk);
      chk_rgb("rst", 0, 0, 0);
      chk("rst_pulse", 32'(bus.collision_pulse), 0);
      chk("rst_sticky", 32'(bus.collision_sticky), 0);
      chk("rst_addr", 32'(bus.sprite_addr), 0);

      // Known defaults, release reset
      bus.player_x = 10'd100; bus.player_y = 10'd200;
      park_cars();
      bus.sprite_x = 10'd900; bus.sprite_y = 10'd900;
      bus.sprite_en = 1'b0; bus.sprite_data = '0; bus.collision_clr = 1'b0;
      rst_n = 1'b1;

      // Safe band pixel: black after 1 cycle, white after 2
      pix(10'd10, 10'd10);
      chk_rgb("lat1", 0, 0, 0);
      tick();
      chk_rgb("lat2_safe", 7, 7, 7);

      pix(10'd110, 10'd210); tick();
      chk_rgb("player", 0, 7, 0);

      // Player over car 0: still green, and this arms the frame accumulator
      set_car(0, 10'd90, 10'd205);
      pix(10'd110, 10'd210); tick();
      chk_rgb("player_car", 0, 7, 0);
      park_cars();

      set_car(0, 10'd280, 10'd80);
      set_car(3, 10'd290, 10'd90);
      pix(10'd300, 10'd96); tick();
      chk_rgb("cars03", 7, 0, 0);
      park_cars();

      set_car(1, 10'd1000, 10'd0);
      pix(10'd20, 10'd10); tick();
      chk_rgb("nowrap", 7, 7, 7);
      park_cars();

      bus.sprite_en = 1'b1;
      bus.sprite_x = 10'd100; bus.sprite_y = 10'd100;
      bus.sprite_data = 9'h1C5;
      pix(10'd105, 10'd102);
      chk("spr_addr", 32'(bus.sprite_addr), 69);
      tick();
      chk_rgb("sprite", 5, 0, 7);

      bus.sprite_x = 10'd100; bus.sprite_y = 10'd0;
      bus.sprite_data = '0;
      pix(10'd105, 10'd5);
      chk("spr_addr2", 32'(bus.sprite_addr), 165);
      tick();
      chk_rgb("transp", 7, 7, 7);

      pix(10'd600, 10'd300);
      chk("addr_hold", 32'(bus.sprite_addr), 165);
      tick();
      chk_rgb("bg", 0, 0, 0);
      bus.sprite_en = 1'b0; bus.sprite_x = 10'd900; bus.sprite_y = 10'd900;

      // Frame end flushes the earlier player/car overlap
      pix(10'd0, 10'd480);
      chk("flush_pulse", 32'(bus.collision_pulse), 1);
      chk("flush_sticky", 32'(bus.collision_sticky), 1);
      tick();
      chk("flush_pulse_end", 32'(bus.collision_pulse), 0);
      bus.collision_clr = 1'b1;
      tick();
      bus.collision_clr = 1'b0;
      chk("flush_clr", 32'(bus.collision_sticky), 0);

      // Player overlaps car 2 at one pixel
      set_car(2, 10'd120, 10'd215);
      pix(10'd125, 10'd220); tick();
      chk_rgb("ovl", 0, 7, 0);
      park_cars();
      pix(10'd600, 10'd300);
      pix(10'd0, 10'd480);
      chk("coll_pulse", 32'(bus.collision_pulse), 1);
      chk("coll_sticky", 32'(bus.collision_sticky), 1);
      pix(10'd1, 10'd480);
      chk("coll_pulse_1cyc", 32'(bus.collision_pulse), 0);

      // Next frame without overlap
      pix(10'd125, 10'd220); tick();
      pix(10'd0, 10'd480);
      chk("nocoll_pulse", 32'(bus.collision_pulse), 0);
      chk("nocoll_sticky", 32'(bus.collision_sticky), 1);

      bus.collision_clr = 1'b1;
      pix(10'd2, 10'd480);
      bus.collision_clr = 1'b0;
      chk("clr_sticky", 32'(bus.collision_sticky), 0);

      // Clear coincident with a pulse of 1
      set_car(2, 10'd120, 10'd215);
      pix(10'd125, 10'd220); tick();
      park_cars();
      bus.collision_clr = 1'b1;
      pix(10'd0, 10'd480);
      bus.collision_clr = 1'b0;
      chk("race_pulse", 32'(bus.collision_pulse), 1);
      chk("race_sticky", 32'(bus.collision_sticky), 1);

      // Reset mid-frame after an overlap
      set_car(2, 10'd120, 10'd215);
      pix(10'd125, 10'd220); tick();
      park_cars();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_sticky", 32'(bus.collision_sticky), 0);
      chk_rgb("mid_rst", 0, 0, 0);
      rst_n = 1'b1;
      pix(10'd600, 10'd300);
      pix(10'd0, 10'd480);
      chk("post_rst_pulse", 32'(bus.collision_pulse), 0);
      chk("post_rst_sticky", 32'(bus.collision_sticky), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
